// File: rtl/perip_bridge.sv
// Peripheral bridge: data RAM, switch/key inputs, LED and seven-segment registers, ms counter.
// The millisecond counter is compiled in only when the macro PERIP_CNT_EN is defined.
module perip_bridge #(
    parameter int DRAM_AW    = 12,
    parameter int CLK_PER_MS = 50000
) (
    input  logic        cpu_clk,
    input  logic        cpu_rst,
    input  logic [31:0] perip_addr,
    input  logic        perip_wen,
    input  logic [1:0]  perip_mask,
    input  logic [31:0] perip_wdata,
    output logic [31:0] perip_rdata,
    input  logic [31:0] sw,
    input  logic [7:0]  key,
    output logic [31:0] led,
    output logic [31:0] seg_data
);

    localparam logic [31:0] DRAM_BASE = 32'h8010_0000;
    localparam logic [31:0] SW_ADDR   = 32'h8020_0000;
    localparam logic [31:0] KEY_ADDR  = 32'h8020_0010;
    localparam logic [31:0] SEG_ADDR  = 32'h8020_0020;
    localparam logic [31:0] LED_ADDR  = 32'h8020_0040;
    localparam logic [31:0] CNT_ADDR  = 32'h8020_0050;
    localparam logic [31:0] CNT_START = 32'h8000_0000;
    localparam logic [31:0] CNT_STOP  = 32'hFFFF_FFFF;

    logic [31:0]        word_addr;
    logic               dram_hit;
    logic [DRAM_AW-1:0] dram_idx;
    logic [3:0]         byte_en;
    logic [31:0]        lane_wdata;
    logic [31:0]        cnt_rdata;
    logic               cnt_wr;
    logic [31:0]        dram [2**DRAM_AW];

    assign word_addr  = {perip_addr[31:2], 2'b00};
    assign dram_hit   = (perip_addr[31:DRAM_AW+2] == DRAM_BASE[31:DRAM_AW+2]);
    assign dram_idx   = perip_addr[DRAM_AW+1:2];
    assign lane_wdata = perip_wdata << {perip_addr[1:0], 3'b000};
    assign cnt_wr     = perip_wen && (word_addr == CNT_ADDR);

    // Misaligned half and word stores leave every byte enable low, so they are dropped.
    always_comb begin
        byte_en = 4'b0000;
        case (perip_mask)
            2'b00: byte_en = 4'b0001 << perip_addr[1:0];
            2'b01: if (!perip_addr[0]) byte_en = 4'b0011 << perip_addr[1:0];
            default: if (perip_addr[1:0] == 2'b00) byte_en = 4'b1111;
        endcase
    end

    // RAM contents survive reset; the read port is asynchronous so it sees pre-write data.
    always_ff @(posedge cpu_clk) begin
        if (!cpu_rst && perip_wen && dram_hit) begin
            for (int i = 0; i < 4; i++) begin
                if (byte_en[i]) dram[dram_idx][8*i +: 8] <= lane_wdata[8*i +: 8];
            end
        end
    end

    always_ff @(posedge cpu_clk) begin
        if (cpu_rst) begin
            led      <= '0;
            seg_data <= '0;
        end else if (perip_wen) begin
            if (word_addr == LED_ADDR) led <= perip_wdata;
            if (word_addr == SEG_ADDR) seg_data <= perip_wdata;
        end
    end

`ifdef PERIP_CNT_EN
    localparam int PRE_W = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(CLK_PER_MS - 1);

    typedef enum logic {STOP, RUN} cnt_state_t;

    cnt_state_t       cnt_state, cnt_state_nxt;
    logic [31:0]      ms_count, ms_count_nxt;
    logic [PRE_W-1:0] prescale, prescale_nxt;

    always_ff @(posedge cpu_clk) begin
        if (cpu_rst) begin
            cnt_state <= STOP;
            ms_count  <= '0;
            prescale  <= '0;
        end else begin
            cnt_state <= cnt_state_nxt;
            ms_count  <= ms_count_nxt;
            prescale  <= prescale_nxt;
        end
    end

    // A start/stop command wins over the prescaler tick in the same cycle.
    always_comb begin
        cnt_state_nxt = cnt_state;
        ms_count_nxt  = ms_count;
        prescale_nxt  = prescale;
        if (cnt_wr && perip_wdata == CNT_START) begin
            cnt_state_nxt = RUN;
            ms_count_nxt  = '0;
            prescale_nxt  = '0;
        end else if (cnt_wr && perip_wdata == CNT_STOP) begin
            cnt_state_nxt = STOP;
        end else if (cnt_state == RUN) begin
            if (prescale == PRE_MAX) begin
                prescale_nxt = '0;
                ms_count_nxt = ms_count + 32'd1;
            end else begin
                prescale_nxt = prescale + 1'b1;
            end
        end
    end

    assign cnt_rdata = ms_count;
`else
    assign cnt_rdata = 32'h0;
`endif

    always_comb begin
        perip_rdata = '0;
        if (dram_hit) begin
            perip_rdata = dram[dram_idx];
        end else begin
            case (word_addr)
                SW_ADDR:  perip_rdata = sw;
                KEY_ADDR: perip_rdata = {24'h0, key};
                LED_ADDR: perip_rdata = led;
                SEG_ADDR: perip_rdata = seg_data;
                CNT_ADDR: perip_rdata = cnt_rdata;
                default:  perip_rdata = '0;
            endcase
        end
    end

endmodule
